// File: rtl/wb_cmd_master_pkg.sv
// Shared types and constants for the Wishbone command initiator (wb_cmd_master).
package wbm_pkg;

    localparam int DAT_W = 32;
    localparam int ADR_W = 32;
    localparam int SEL_W = 4;

    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam logic [DAT_W-1:0] ERR_DATA = 32'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command, response and Wishbone bus signals of wb_cmd_master grouped in one bundle.
// Both cmd and rsp ports use valid/ready: a beat transfers on a rising edge where
// valid and ready are both high, and the source holds valid and its payload until then.
interface wb_cmd_master_if;
    import wbm_pkg::*;

    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic             cmd_we_i;
    logic [ADR_W-1:0] cmd_adr_i;
    logic [DAT_W-1:0] cmd_dat_i;
    logic [SEL_W-1:0] cmd_sel_i;

    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [DAT_W-1:0] rsp_dat_o;
    logic             rsp_err_o;

    logic             wbm_cyc_o;
    logic             wbm_stb_o;
    logic             wbm_we_o;
    logic [SEL_W-1:0] wbm_sel_o;
    logic [ADR_W-1:0] wbm_adr_o;
    logic [DAT_W-1:0] wbm_dat_o;
    logic             wbm_ack_i;
    logic [DAT_W-1:0] wbm_dat_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o,
        input  rsp_ready_i,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_ack_i, wbm_dat_i
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o,
        output rsp_ready_i,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_ack_i, wbm_dat_i
    );

endinterface

// File: rtl/wbm_timeout.sv
// Bus-cycle watchdog: counts un-acknowledged BUS cycles, flags the last allowed one.
module wbm_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = 16'd0;
        end else if (en_i && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/wb_cmd_master.sv
// Single-beat Wishbone classic initiator driven from a valid/ready command port.
// Optional watchdog abort of unacknowledged cycles is built when WBM_TIMEOUT_EN is defined.
module wb_cmd_master
    import wbm_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    wb_cmd_master_if.master   bus,
    output state_t            state_o
);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("wb_cmd_master: TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic [ADR_W-1:0] adr_q, adr_d;
    logic [DAT_W-1:0] dat_q, dat_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [DAT_W-1:0] rdat_q, rdat_d;
    logic             err_q, err_d;
    logic             cmd_fire;
    logic             timeout_hit;

    assign cmd_fire = (state_q == IDLE) && bus.cmd_valid_i;

`ifdef WBM_TIMEOUT_EN
    wbm_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (wb_clk_i),
        .rst_n     (wb_rst_n_i),
        .clr_i     (cmd_fire),
        .en_i      ((state_q == BUS) && !bus.wbm_ack_i),
        .expired_o (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rdat_d  = rdat_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    we_d    = bus.cmd_we_i;
                    adr_d   = bus.cmd_adr_i;
                    dat_d   = bus.cmd_dat_i;
                    sel_d   = bus.cmd_sel_i;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Ack is tested first so it wins over a watchdog expiry in the same cycle.
                if (bus.wbm_ack_i) begin
                    rdat_d  = we_q ? '0 : bus.wbm_dat_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timeout_hit) begin
                    rdat_d  = ERR_DATA;
                    err_d   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdat_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdat_q  <= rdat_d;
            err_q   <= err_d;
        end
    end

    assign bus.cmd_ready_o = (state_q == IDLE);
    assign bus.wbm_cyc_o   = (state_q == BUS);
    assign bus.wbm_stb_o   = (state_q == BUS);
    assign bus.wbm_we_o    = we_q;
    assign bus.wbm_adr_o   = adr_q;
    assign bus.wbm_dat_o   = dat_q;
    assign bus.wbm_sel_o   = sel_q;
    assign bus.rsp_valid_o = (state_q == RESP);
    assign bus.rsp_dat_o   = rdat_q;
    assign bus.rsp_err_o   = err_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed vector table, reset corner case,
// and randomized transactions checked against a transaction-level model.
module tb_wb_cmd_master;
    import wbm_pkg::*;

    localparam int unsigned T = 8;
`ifdef WBM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic   clk;
    logic   rst_n;
    state_t dbg_state;
    int     checks;
    int     failures;

    logic [31:0] exp_q[$];
    logic [31:0] exp_err_q[$];

    wb_cmd_master_if bus_if();

    wb_cmd_master #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus_if),
        .state_o    (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit actual=expired required=finish");
        $fatal(1, "simulation time limit");
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: the slave acks after w wait cycles unless the
    // watchdog allows only T bus cycles; writes return zero data.
    function automatic void model(input logic we, input logic [31:0] rdat, input int w,
                                  output logic [31:0] d, output logic e, output int k);
        if (TO_EN && (w >= int'(T))) begin
            d = 32'h0;
            e = 1'b1;
            k = int'(T);
        end else begin
            d = we ? 32'h0 : rdat;
            e = 1'b0;
            k = w + 1;
        end
    endfunction

    // ---------------- driver ----------------
    task automatic idle_inputs();
        bus_if.cmd_valid_i = 1'b0;
        bus_if.cmd_we_i    = 1'b0;
        bus_if.cmd_adr_i   = 32'h0;
        bus_if.cmd_dat_i   = 32'h0;
        bus_if.cmd_sel_i   = 4'h0;
        bus_if.rsp_ready_i = 1'b0;
        bus_if.wbm_ack_i   = 1'b0;
        bus_if.wbm_dat_i   = 32'h0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cmd_ready"}, 32'(bus_if.cmd_ready_o), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid_o), 32'd0);
        chk({tag, "_rsp_err"},   32'(bus_if.rsp_err_o),   32'd0);
        chk({tag, "_rsp_dat"},   bus_if.rsp_dat_o,        32'h0);
        chk({tag, "_cyc"},       32'(bus_if.wbm_cyc_o),   32'd0);
        chk({tag, "_stb"},       32'(bus_if.wbm_stb_o),   32'd0);
        chk({tag, "_we"},        32'(bus_if.wbm_we_o),    32'd0);
        chk({tag, "_sel"},       32'(bus_if.wbm_sel_o),   32'd0);
        chk({tag, "_adr"},       bus_if.wbm_adr_o,        32'h0);
        chk({tag, "_dat"},       bus_if.wbm_dat_o,        32'h0);
    endtask

    // Entered and left on a negedge. w = wait cycles before ack, rdly = cycles rsp_ready held low.
    task automatic do_txn(input string tag, input logic we, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel, input int w,
                          input logic [31:0] rdat, input int rdly,
                          input logic [31:0] exp_dat, input logic exp_err, input int exp_k);
        int k;
        logic [31:0] held;
        exp_q.push_back(exp_dat);
        exp_err_q.push_back(32'(exp_err));
        chk({tag, "_cmd_ready_idle"}, 32'(bus_if.cmd_ready_o), 32'd1);
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_we_i    = we;
        bus_if.cmd_adr_i   = adr;
        bus_if.cmd_dat_i   = dat;
        bus_if.cmd_sel_i   = sel;
        @(negedge clk);
        bus_if.cmd_valid_i = 1'b0;
        bus_if.cmd_we_i    = ~we;
        bus_if.cmd_adr_i   = $urandom;
        bus_if.cmd_dat_i   = $urandom;
        bus_if.cmd_sel_i   = ~sel;
        k = 0;
        while (bus_if.wbm_cyc_o && (k < 1000)) begin
            chk({tag, "_stb"},       32'(bus_if.wbm_stb_o),   32'd1);
            chk({tag, "_cmd_ready_bus"}, 32'(bus_if.cmd_ready_o), 32'd0);
            chk({tag, "_rsp_valid_bus"}, 32'(bus_if.rsp_valid_o), 32'd0);
            chk({tag, "_wbm_we"},    32'(bus_if.wbm_we_o),    32'(we));
            chk({tag, "_wbm_adr"},   bus_if.wbm_adr_o,        adr);
            chk({tag, "_wbm_dat"},   bus_if.wbm_dat_o,        dat);
            chk({tag, "_wbm_sel"},   32'(bus_if.wbm_sel_o),   32'(sel));
            bus_if.wbm_ack_i = (k == w);
            bus_if.wbm_dat_i = (k == w) ? rdat : $urandom;
            @(negedge clk);
            bus_if.wbm_ack_i = 1'b0;
            k++;
        end
        chk({tag, "_bus_cycles"}, 32'(k), 32'(exp_k));
        chk({tag, "_rsp_valid"}, 32'(bus_if.rsp_valid_o), 32'd1);
        chk({tag, "_stb_low"},   32'(bus_if.wbm_stb_o),   32'd0);
        if (exp_q.size() > 0) begin
            chk({tag, "_rsp_dat"}, bus_if.rsp_dat_o, exp_q.pop_front());
            chk({tag, "_rsp_err"}, 32'(bus_if.rsp_err_o), exp_err_q.pop_front());
        end
        held = bus_if.rsp_dat_o;
        for (int i = 0; i < rdly; i++) begin
            bus_if.wbm_ack_i = 1'($urandom_range(0, 1));
            bus_if.wbm_dat_i = $urandom;
            @(negedge clk);
            chk({tag, "_hold_valid"},     32'(bus_if.rsp_valid_o), 32'd1);
            chk({tag, "_hold_dat"},       bus_if.rsp_dat_o,        held);
            chk({tag, "_hold_cmd_ready"}, 32'(bus_if.cmd_ready_o), 32'd0);
            chk({tag, "_hold_cyc"},       32'(bus_if.wbm_cyc_o),   32'd0);
        end
        bus_if.wbm_ack_i   = 1'b0;
        bus_if.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus_if.rsp_ready_i = 1'b0;
        chk({tag, "_rsp_done"},  32'(bus_if.rsp_valid_o), 32'd0);
        chk({tag, "_cmd_ready_back"}, 32'(bus_if.cmd_ready_o), 32'd1);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        int          w;
        logic [31:0] rdat;
        int          rdly;
        logic [31:0] exp_dat;
        logic        exp_err;
        int          exp_k;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [31:0] e_dat;
        logic        e_err;
        int          e_k;
        logic        r_we;
        logic [31:0] r_adr, r_dat, r_rdat;
        logic [3:0]  r_sel;
        int          r_w, r_dly;

        checks   = 0;
        failures = 0;

        vecs[0] = '{"wr_wait3",   1'b1, 32'h3000_0004, 32'hA5A5_0001, 4'hF, 3, 32'hDEAD_BEEF, 0,
                    32'h0, 1'b0, 4};
        vecs[1] = '{"rd_zero",    1'b0, 32'h3000_0000, 32'h0000_0000, 4'hF, 0, 32'h1234_5678, 0,
                    32'h1234_5678, 1'b0, 1};
        vecs[2] = '{"rd_bp5",     1'b0, 32'h3000_0010, 32'h5555_AAAA, 4'h3, 1, 32'h0BAD_F00D, 5,
                    32'h0BAD_F00D, 1'b0, 2};
        vecs[3] = '{"rd_noack",   1'b0, 32'h3000_0020, 32'h0000_0000, 4'hF, 20, 32'h1111_2222, 2,
                    TO_EN ? 32'h0 : 32'h1111_2222, TO_EN, TO_EN ? 8 : 21};
        vecs[4] = '{"rd_ack_lim", 1'b0, 32'h3000_0030, 32'h0000_0000, 4'hF, int'(T) - 1, 32'hCAFE_F00D, 1,
                    32'hCAFE_F00D, 1'b0, int'(T)};
        vecs[5] = '{"wr_sel3",    1'b1, 32'h3000_0044, 32'h0102_0304, 4'h3, int'(T) - 2, 32'hFFFF_FFFF, 0,
                    32'h0, 1'b0, int'(T) - 1};

        // reset
        rst_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_txn(vecs[i].name, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].w,
                   vecs[i].rdat, vecs[i].rdly, vecs[i].exp_dat, vecs[i].exp_err, vecs[i].exp_k);
        end

`ifndef WBM_TIMEOUT_EN
        // Without the watchdog the bus must wait for ack indefinitely.
        do_txn("rd_wait150", 1'b0, 32'h3000_0050, 32'h0, 4'hF, 150, 32'h7777_8888, 0,
               32'h7777_8888, 1'b0, 151);
`endif

        // reset while a cycle is on the bus
        bus_if.cmd_valid_i = 1'b1;
        bus_if.cmd_we_i    = 1'b1;
        bus_if.cmd_adr_i   = 32'h3000_0060;
        bus_if.cmd_dat_i   = 32'h9999_0000;
        bus_if.cmd_sel_i   = 4'hF;
        @(negedge clk);
        bus_if.cmd_valid_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_cyc_before", 32'(bus_if.wbm_cyc_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc",       32'(bus_if.wbm_cyc_o),   32'd0);
        chk("mid_rst_stb",       32'(bus_if.wbm_stb_o),   32'd0);
        chk("mid_rst_rsp_valid", 32'(bus_if.rsp_valid_o), 32'd0);
        @(negedge clk);
        check_reset_values("mid_rst");
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_no_rsp", 32'(bus_if.rsp_valid_o), 32'd0);
        end
        do_txn("post_rst_rd", 1'b0, 32'h3000_0000, 32'h0, 4'hF, 2, 32'h600D_0001, 1,
               32'h600D_0001, 1'b0, 3);

        // randomized transactions against the model
        for (int n = 0; n < 40; n++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_adr  = $urandom;
            r_dat  = $urandom;
            r_sel  = 4'($urandom_range(0, 15));
            r_w    = $urandom_range(0, 12);
            r_rdat = $urandom;
            r_dly  = $urandom_range(0, 3);
            model(r_we, r_rdat, r_w, e_dat, e_err, e_k);
            do_txn("rand", r_we, r_adr, r_dat, r_sel, r_w, r_rdat, r_dly, e_dat, e_err, e_k);
        end

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic initiator that turns single-beat commands from a ready/valid command port into Wishbone read or write cycles. It drives the slave port of a user project wrapper (wbs_* signals) from user-area logic, such as an LA-driven debug path or an on-chip sequencer. It returns read data and status on a ready/valid response port. An optional watchdog aborts cycles that a slave never acknowledges.

## Interface
- TIMEOUT_CYCLES, 255: cycles with wbm_stb_o high and no ack before abort; legal range 1..65535.
- wb_clk_i  in  1  sole clock; all logic on rising edge.
- wb_rst_n_i  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when high together with cmd_valid_i.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  32  byte address.
- cmd_dat_i  in  32  write data.
- cmd_sel_i  in  4  byte selects.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when high together with rsp_valid_o.
- rsp_dat_o  out  32  read data; 0 for writes and on error.
- rsp_err_o  out  1  1 = cycle aborted by timeout.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone controls.
- wbm_sel_o  out  4  byte selects.
- wbm_adr_o, wbm_dat_o  out  32 each  address and write data.
- wbm_ack_i  in  1  slave acknowledge.
- wbm_dat_i  in  32  slave read data.

## Operation
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd handshake, register we/adr/dat/sel onto the wbm_* outputs and go to BUS.
- BUS:
  - wbm_cyc_o = wbm_stb_o = 1; all wbm_* outputs stable.
  - On wbm_ack_i high: capture wbm_dat_i (reads only, else 0), set rsp_err_o = 0, go to RESP.
- RESP:
  - rsp_valid_o = 1; rsp_dat_o and rsp_err_o hold their values.
  - On rsp_ready_i high, go to IDLE.
- cmd_ready_o is low in BUS and RESP. Only one transaction is ever outstanding.
- wbm_adr_o, wbm_dat_o, wbm_sel_o and wbm_we_o keep their last values outside BUS. Slaves must qualify them with cyc/stb.
- Timeout:
  - A 16-bit counter clears on entry to BUS and increments each BUS cycle without ack.
  - When count reaches TIMEOUT_CYCLES-1 with no ack: go to RESP with rsp_err_o = 1 and rsp_dat_o = 0.
  - If ack and the timeout limit fall in the same cycle, ack wins: normal response, rsp_err_o = 0.
- Reset mid-transaction: cyc/stb drop immediately (asynchronous). The FSM returns to IDLE and the in-flight command is lost with no response.
- Reset values: cmd_ready_o = 1, rsp_valid_o = 0, rsp_err_o = 0, rsp_dat_o = 0, and every wbm_* output = 0.

## Timing
- Command handshake at edge N: wbm_cyc_o/wbm_stb_o are high from cycle N+1.
- Ack sampled at edge M: cyc/stb are low in cycle M+1, and rsp_valid_o is high in M+1.
- A zero-wait-state slave (ack in the first BUS cycle) gives 2 cycles from command handshake to rsp_valid_o.
- Next command: cmd_ready_o is high the cycle after the response handshake. Back-to-back throughput is 1 transaction per 3 cycles minimum.
- Timeout abort: rsp_valid_o rises exactly TIMEOUT_CYCLES cycles after cyc/stb first rise.
- An ack arriving while not in BUS is ignored.

## Configuration
- WBM_TIMEOUT_EN defined: the watchdog counter exists and behaves as above.
- WBM_TIMEOUT_EN undefined:
  - No counter is built.
  - BUS waits indefinitely for wbm_ack_i.
  - rsp_err_o is tied to 0.
  - TIMEOUT_CYCLES is ignored.

## Structure
- Package wbm_pkg holds:
  - the FSM state enum (IDLE/BUS/RESP);
  - the default timeout constant;
  - the response-on-error data constant (32'h0);
  - the width constants for data (32), address (32) and sel (4).
- Sub-module wbm_timeout is the natural split: clear/enable inputs and an expired output. It is instantiated only under WBM_TIMEOUT_EN.

## Test plan
- Write with cmd_adr_i = 32'h3000_0004, cmd_dat_i = 32'hA5A5_0001, sel = 4'hF, ack after 3 wait cycles:
  - wbm_we_o = 1 and the bus fields match the command while cyc/stb are high;
  - response is rsp_err_o = 0, rsp_dat_o = 0.
- Read from 32'h3000_0000 with zero-wait ack and wbm_dat_i = 32'h1234_5678:
  - rsp_valid_o is high 2 cycles after the command handshake;
  - rsp_dat_o = 32'h1234_5678.
- Backpressure: hold rsp_ready_i low for 5 cycles:
  - rsp_valid_o and rsp_dat_o stay stable;
  - cmd_ready_o stays 0 until the response handshake, then returns to 1.
- Timeout with TIMEOUT_CYCLES = 8 and no ack:
  - cyc/stb high for exactly 8 cycles, then rsp_err_o = 1, rsp_dat_o = 0;
  - with WBM_TIMEOUT_EN undefined, cyc stays high for at least 100 cycles.
- Ack in the same cycle as the timeout limit, with wbm_dat_i = 32'hCAFE_F00D:
  - rsp_err_o = 0, rsp_dat_o = 32'hCAFE_F00D.
- Assert wb_rst_n_i low during BUS:
  - cyc/stb go low within the same cycle, with no rsp_valid_o;
  - after release, a new read completes normally.
